ysyx_24110006_store_unit: RTL and testbench

AXI4-Lite write-channel initiator that turns one core store request into one AXI write transaction (AW, W, B) and returns the write response to the core. It sits between the LSU store path and the write-slave ports of memory-mapped peripherals (UART, SRAM), driving the same AW/W/B signal set those slaves accept. Only one transaction is outstanding at a time, and all bus outputs are registered.

---
 rtl/ysyx_24110006_pkg.sv | 21 ++
 rtl/ysyx_24110006_store_fmt.sv | 44 ++++
 rtl/ysyx_24110006_store_unit.sv | 158 +++++++++++++++
 tb/tb_ysyx_24110006_store_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24110006_pkg.sv
// Shared encodings for the ysyx_24110006 LSU bus initiators: access sizes,
// AXI response codes and the store-unit state set.
package ysyx_24110006_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/ysyx_24110006_store_fmt.sv
// Combinational store formatting: byte-lane shift of right-aligned data,
// strobe generation and the alignment/size legality check.
module ysyx_24110006_store_fmt
   import ysyx_24110006_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [1:0]        off_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [1:0]        size_i,
   output logic [DATA_W-1:0] wdata_o,
   output logic [3:0]        wstrb_o,
   output logic              misaligned_o
);

   logic [3:0] base;

   always_comb begin
      base         = 4'b0000;
      misaligned_o = 1'b1;
      case (size_i)
         SZ_B: begin
            base         = 4'b0001;
            misaligned_o = 1'b0;
         end
         SZ_H: begin
            base         = 4'b0011;
            misaligned_o = off_i[0];
         end
         SZ_W: begin
            base         = 4'b1111;
            misaligned_o = |off_i;
         end
         default: begin
            // reserved size is treated exactly like a misaligned access
            base         = 4'b0000;
            misaligned_o = 1'b1;
         end
      endcase
      wdata_o = data_i << {off_i, 3'b000};
      wstrb_o = base << off_i;
   end

endmodule

// File: rtl/ysyx_24110006_store_unit.sv
// AXI4-Lite write initiator: one core store becomes one AW/W/B transaction,
// with a single transaction outstanding and all bus outputs registered.
module ysyx_24110006_store_unit
   import ysyx_24110006_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [DATA_W-1:0] i_req_data,
   input  logic [1:0]        i_req_size,
   output logic              o_rsp_valid,
   output logic              o_rsp_err,
   input  logic              i_rsp_ready,
   output logic [ADDR_W-1:0] o_axi_awaddr,
   output logic              o_axi_awvalid,
   input  logic              i_axi_awready,
   output logic [DATA_W-1:0] o_axi_wdata,
   output logic [7:0]        o_axi_wstrb,
   output logic              o_axi_wvalid,
   input  logic              i_axi_wready,
   input  logic [1:0]        i_axi_bresp,
   input  logic              i_axi_bvalid,
   output logic              o_axi_bready
);

   state_e            state_q, state_d;
   logic              awvalid_q, awvalid_d;
   logic              wvalid_q, wvalid_d;
   logic              bready_q, bready_d;
   logic              aw_done_q, aw_done_d;
   logic              w_done_q, w_done_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] awaddr_q, awaddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;

   logic [DATA_W-1:0] fmt_wdata;
   logic [3:0]        fmt_wstrb;
   logic              fmt_misaligned;
   logic              aw_hs, w_hs;

   ysyx_24110006_store_fmt #(.DATA_W(DATA_W)) u_fmt (
      .off_i        (i_req_addr[1:0]),
      .data_i       (i_req_data),
      .size_i       (i_req_size),
      .wdata_o      (fmt_wdata),
      .wstrb_o      (fmt_wstrb),
      .misaligned_o (fmt_misaligned)
   );

   assign aw_hs = awvalid_q & i_axi_awready;
   assign w_hs  = wvalid_q & i_axi_wready;

   always_comb begin
      state_d   = state_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      err_d     = err_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      case (state_q)
         ST_IDLE: begin
            if (i_req_valid) begin
               awaddr_d  = i_req_addr;
               wdata_d   = fmt_wdata;
               wstrb_d   = fmt_wstrb;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               if (fmt_misaligned) begin
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  err_d     = 1'b0;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = ST_SEND;
               end
            end
         end
         ST_SEND: begin
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (w_hs) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            // bready is raised only once both channels have handed over
            if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
               bready_d = 1'b1;
               state_d  = ST_RESP;
            end
         end
         ST_RESP: begin
            if (i_axi_bvalid && bready_q) begin
               err_d    = (i_axi_bresp != RESP_OKAY);
               bready_d = 1'b0;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (i_rsp_ready) begin
               err_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q   <= ST_IDLE;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         err_q     <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         state_q   <= state_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         err_q     <= err_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
      end
   end

   // ready is masked by reset so it reads 0 throughout the reset cycle
   assign o_req_ready   = (state_q == ST_IDLE) & ~i_reset;
   assign o_rsp_valid   = (state_q == ST_DONE);
   assign o_rsp_err     = err_q;
   assign o_axi_awaddr  = awaddr_q;
   assign o_axi_awvalid = awvalid_q;
   assign o_axi_wdata   = wdata_q;
   assign o_axi_wstrb   = {4'b0000, wstrb_q};
   assign o_axi_wvalid  = wvalid_q;
   assign o_axi_bready  = bready_q;

endmodule

// File: tb/tb_ysyx_24110006_store_unit.sv
// Self-checking bench for the store unit: directed cases plus random stores
// against a slave model and an arithmetic reference of the store rules.
module tb_ysyx_24110006_store_unit;

   logic        clk = 1'b0;
   logic        i_reset;
   logic        i_req_valid;
   logic        o_req_ready;
   logic [31:0] i_req_addr;
   logic [31:0] i_req_data;
   logic [1:0]  i_req_size;
   logic        o_rsp_valid;
   logic        o_rsp_err;
   logic        i_rsp_ready;
   logic [31:0] o_axi_awaddr;
   logic        o_axi_awvalid;
   logic        i_axi_awready;
   logic [31:0] o_axi_wdata;
   logic [7:0]  o_axi_wstrb;
   logic        o_axi_wvalid;
   logic        i_axi_wready;
   logic [1:0]  i_axi_bresp;
   logic        i_axi_bvalid;
   logic        o_axi_bready;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_stores = 0;
   logic [31:0] last_awaddr;
   logic [31:0] last_wdata;
   logic [7:0]  last_wstrb;
   logic        last_err;

   always #5 clk = ~clk;

   ysyx_24110006_store_unit dut (
      .i_clock       (clk),
      .i_reset       (i_reset),
      .i_req_valid   (i_req_valid),
      .o_req_ready   (o_req_ready),
      .i_req_addr    (i_req_addr),
      .i_req_data    (i_req_data),
      .i_req_size    (i_req_size),
      .o_rsp_valid   (o_rsp_valid),
      .o_rsp_err     (o_rsp_err),
      .i_rsp_ready   (i_rsp_ready),
      .o_axi_awaddr  (o_axi_awaddr),
      .o_axi_awvalid (o_axi_awvalid),
      .i_axi_awready (i_axi_awready),
      .o_axi_wdata   (o_axi_wdata),
      .o_axi_wstrb   (o_axi_wstrb),
      .o_axi_wvalid  (o_axi_wvalid),
      .i_axi_wready  (i_axi_wready),
      .i_axi_bresp   (i_axi_bresp),
      .i_axi_bvalid  (i_axi_bvalid),
      .o_axi_bready  (o_axi_bready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      i_req_valid   = 1'b0;
      i_rsp_ready   = 1'b0;
      i_axi_awready = 1'b0;
      i_axi_wready  = 1'b0;
      i_axi_bvalid  = 1'b0;
      i_axi_bresp   = 2'b00;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_awvalid"}, 32'(o_axi_awvalid), 0);
      check({tag, "_wvalid"},  32'(o_axi_wvalid), 0);
      check({tag, "_bready"},  32'(o_axi_bready), 0);
      check({tag, "_rspv"},    32'(o_rsp_valid), 0);
      check({tag, "_rsperr"},  32'(o_rsp_err), 0);
      check({tag, "_awaddr"},  o_axi_awaddr, 0);
      check({tag, "_wdata"},   o_axi_wdata, 0);
      check({tag, "_wstrb"},   32'(o_axi_wstrb), 0);
   endtask

   // Runs one store starting at a negedge. Slave ready delays count cycles
   // from the first cycle the DUT can present valid (c = 1).
   task automatic run_store(input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] size, input int aw_dly, input int w_dly,
                            input int b_dly, input logic [1:0] bresp, input int rsp_dly,
                            input bit early_b, input int exp_lat);
      int          off, nbytes, c, bwait, hold, lat;
      logic [31:0] exp_wdata;
      logic [7:0]  exp_strb;
      bit          mis, exp_err, aw_seen, w_seen, b_seen, rsp_exp, done, done_now;
      bit          aw_hs, w_hs, b_hs;
      off       = int'(addr % 4);
      nbytes    = (size == 2'd3) ? 0 : (1 << size);
      mis       = (size == 2'd3) ? 1'b1 : ((off % nbytes) != 0);
      exp_wdata = data << (8 * off);
      exp_strb  = 8'((((1 << nbytes) - 1) << off) & 32'hF);
      exp_err   = mis || (bresp != 2'b00);
      c = 1; bwait = 0; hold = 0; lat = 0;
      aw_seen = 0; w_seen = 0; b_seen = 0; done = 0; done_now = 0;
      rsp_exp = mis;

      check("req_ready", 32'(o_req_ready), 1);
      i_req_valid = 1'b1;
      i_req_addr  = addr;
      i_req_data  = data;
      i_req_size  = size;
      @(negedge clk);
      i_req_valid = 1'b0;

      while (!done && c <= 300) begin
         i_axi_awready = (c > aw_dly);
         i_axi_wready  = (c > w_dly);
         if (aw_seen && w_seen) bwait++;
         i_axi_bvalid = !mis && !b_seen && (early_b || (aw_seen && w_seen && bwait > b_dly));
         i_axi_bresp  = i_axi_bvalid ? bresp : 2'b00;

         if (mis) begin
            check("mis_awvalid", 32'(o_axi_awvalid), 0);
            check("mis_wvalid",  32'(o_axi_wvalid), 0);
         end
         if (o_axi_awvalid) begin
            check("aw_drop", 32'(aw_seen), 0);
            check("awaddr", o_axi_awaddr, addr);
         end
         if (o_axi_wvalid) begin
            check("w_drop", 32'(w_seen), 0);
            check("wdata", o_axi_wdata, exp_wdata);
            check("wstrb", 32'(o_axi_wstrb), 32'(exp_strb));
         end
         if (!mis) check("bready", 32'(o_axi_bready), 32'(aw_seen && w_seen && !b_seen));
         check("rsp_valid", 32'(o_rsp_valid), 32'(rsp_exp));
         i_rsp_ready = 1'b0;
         if (rsp_exp) begin
            if (lat == 0) lat = c;
            check("rsp_err", 32'(o_rsp_err), 32'(exp_err));
            last_err    = o_rsp_err;
            i_rsp_ready = (hold >= rsp_dly);
            hold++;
         end

         aw_hs    = o_axi_awvalid && i_axi_awready;
         w_hs     = o_axi_wvalid && i_axi_wready;
         b_hs     = i_axi_bvalid && o_axi_bready;
         done_now = rsp_exp && i_rsp_ready;
         if (aw_hs) last_awaddr = o_axi_awaddr;
         if (w_hs) begin
            last_wdata = o_axi_wdata;
            last_wstrb = o_axi_wstrb;
         end
         @(negedge clk);
         c++;
         if (aw_hs) aw_seen = 1;
         if (w_hs) w_seen = 1;
         if (b_hs) begin
            b_seen  = 1;
            rsp_exp = 1;
         end
         done = done_now;
      end

      i_axi_awready = 1'b0;
      i_axi_wready  = 1'b0;
      i_axi_bvalid  = 1'b0;
      i_rsp_ready   = 1'b0;
      check("timeout", 32'(done), 1);
      check("rsp_clear", 32'(o_rsp_valid), 0);
      check("idle_ready", 32'(o_req_ready), 1);
      if (mis) check("mis_latency", 32'(lat), 1);
      else if (exp_lat > 0) check("latency", 32'(lat), 32'(exp_lat));
      n_stores++;
      $display("store %0d: addr=%h data=%h size=%0d err=%0d latency=%0d",
               n_stores, addr, data, size, exp_err, lat);
   endtask

   initial begin
      logic [31:0] ra, rd;
      logic [1:0]  rs;
      idle_inputs();
      i_req_addr = '0;
      i_req_data = '0;
      i_req_size = '0;
      i_reset    = 1'b1;
      last_awaddr = '0;
      last_wdata  = '0;
      last_wstrb  = '0;
      last_err    = 1'b0;

      @(negedge clk);
      @(negedge clk);
      check_all_zero("rst");
      check("rst_req_ready", 32'(o_req_ready), 0);
      i_reset = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 32'(o_req_ready), 1);

      // byte store, always-ready slave
      run_store(32'hA000_03F9, 32'h0000_0041, 2'd0, 0, 0, 0, 2'b00, 0, 0, 3);
      check("tp1_awaddr", last_awaddr, 32'hA000_03F9);
      check("tp1_wdata", last_wdata, 32'h0000_4100);
      check("tp1_wstrb", 32'(last_wstrb), 32'h02);

      // word store, slow AW and slower W
      run_store(32'h8000_0004, 32'hDEAD_BEEF, 2'd2, 2, 5, 0, 2'b00, 0, 0, 0);
      check("tp2_wstrb", 32'(last_wstrb), 32'h0F);
      check("tp2_wdata", last_wdata, 32'hDEAD_BEEF);

      // misaligned half
      run_store(32'h1000_0001, 32'h0000_1234, 2'd1, 0, 0, 0, 2'b00, 0, 0, 1);
      check("tp3_err", 32'(last_err), 1);

      // SLVERR, response held back for 4 cycles
      run_store(32'h8000_0010, 32'h1122_3344, 2'd2, 0, 0, 1, 2'b10, 4, 0, 0);
      check("tp4_err", 32'(last_err), 1);

      // reset while W is still pending and AW has already completed
      i_req_valid = 1'b1;
      i_req_addr  = 32'h8000_0020;
      i_req_data  = 32'h5555_AAAA;
      i_req_size  = 2'd2;
      @(negedge clk);
      i_req_valid   = 1'b0;
      i_axi_awready = 1'b1;
      i_axi_wready  = 1'b0;
      @(negedge clk);
      i_axi_awready = 1'b0;
      check("tp5_aw_gone", 32'(o_axi_awvalid), 0);
      check("tp5_w_pending", 32'(o_axi_wvalid), 1);
      i_reset = 1'b1;
      @(negedge clk);
      check_all_zero("tp5");
      check("tp5_ready_in_rst", 32'(o_req_ready), 0);
      i_reset = 1'b0;
      @(negedge clk);
      check("tp5_ready_after", 32'(o_req_ready), 1);
      run_store(32'hA000_03FA, 32'h0000_007E, 2'd0, 0, 0, 0, 2'b00, 0, 0, 3);
      check("tp5_wdata", last_wdata, 32'h007E_0000);

      // early bvalid must wait for W to finish
      run_store(32'h8000_0040, 32'hCAFE_F00D, 2'd1, 0, 4, 0, 2'b00, 0, 1, 0);
      check("tp6_wstrb", 32'(last_wstrb), 32'h03);

      for (int i = 0; i < 150; i++) begin
         ra = $urandom;
         rd = $urandom;
         rs = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) != 0 && rs != 2'd3)
            ra = ra & ~((32'd1 << rs) - 32'd1);
         run_store(ra, rd, rs, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
